wb_packer: RTL and testbench
============================

// Module: wb_packer
// PURPOSE
//  Downstream writeback stage for the engine. Collects the serial 16-bit results
//  (output_en/output_data) into BURST_LEN-word bursts and hands them to the DMA
//  write path with a valid/ready handshake. Returns output_count to the engine.
//  A small burst FIFO absorbs DMA stalls; the engine has no backpressure.
// PARAMETERS
//  BURST_LEN   8   words per burst; matches `BURST_LEN
//  DATA_W      16  bits per word (fp16)
//  ADDR_W      10  burst address width; wraps modulo 2^ADDR_W
//  FIFO_DEPTH  4   burst FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1                 clock
//  rst_n        in   1                 async active-low reset
//  start        in   1                 pulse: clear counters/flags, load base_addr, enter RUN
//  base_addr    in   ADDR_W            first burst address
//  flush        in   1                 pulse: close partial burst, drain FIFO
//  in_en        in   1                 engine output_en; word valid this cycle
//  in_data      in   DATA_W            engine output_data
//  output_count out  10                words accepted since start; to engine
//  out_valid    out  1                 burst valid to DMA
//  out_ready    in   1                 DMA accepts burst
//  out_data     out  DATA_W*BURST_LEN  word k in bits [k*DATA_W +: DATA_W]
//  out_addr     out  ADDR_W            burst address
//  out_mask     out  BURST_LEN         1 = word lane valid
//  busy         out  1                 state != IDLE
//  done         out  1                 1-cycle pulse after drain completes
//  overflow     out  1                 sticky; burst dropped because FIFO was full
// BEHAVIOUR
//  Reset: every output is 0; state IDLE; FIFO empty; lane index 0; addr 0.
//  States: IDLE -start-> RUN -flush-> FLUSH -(FIFO empty, out_valid=0)-> DONE -> IDLE.
//   DONE lasts 1 cycle and drives done=1. start is ignored outside IDLE.
//   in_en is ignored outside RUN.
//  Packing: in RUN, in_en writes in_data to lane[idx], sets mask bit idx, and increments idx
//   and output_count. Word 0 goes to bits [15:0].
//   - idx==BURST_LEN-1 with in_en: push {data, mask=all 1s, addr} to FIFO the next cycle.
//     Then idx<=0, mask<=0, addr<=addr+1.
//   - Push with FIFO full: burst dropped, overflow<=1, addr still advances.
//  Latency: the last word of a burst is visible on out_data 2 cycles after its in_en,
//   provided the FIFO was empty.
//  Handshake: out_valid/out_data/out_addr/out_mask are stable while out_valid && !out_ready.
//   The FIFO pops when out_valid && out_ready. A push and a pop in the same cycle at full are legal.
//  Flush:
//   - in_en and flush in the same cycle: the word is packed first, then the flush takes effect.
//   - On entry to FLUSH with idx>0: push one partial burst. Unfilled lanes are 0, mask
//     marks the filled lanes, addr advances.
//   - With idx==0: no push.
//  output_count saturates at 10'h3FF. It holds its value after DONE until the next start.
//  Reset mid-burst: all state is discarded, no burst is emitted, out_valid drops immediately.
// CONFIGURATION
//  WB_PERF_CNT_EN defined:
//   - Adds output port stall_cycles [31:0], reset 0 and cleared on start.
//   - It increments every cycle that out_valid && !out_ready.
//  WB_PERF_CNT_EN undefined: the port and counter do not exist. All other behaviour is identical.
// TESTING
//  1. start, base 0x010; 8 in_en words 0x3C00..0x3C07, out_ready=1
//     -> one burst at addr 0x010, mask 8'hFF, word0=0x3C00; output_count=8.
//  2. 11 words, then flush
//     -> bursts at 0x010 and 0x011. The second has mask 8'h07 and words 3..7 = 0.
//     Then done pulses once.
//  3. out_ready=0; 40 words (5 bursts) with FIFO_DEPTH=4
//     -> overflow=1, FIFO holds 4 bursts. Release ready -> exactly 4 pops with addrs
//     base..base+3. out_data is stable while stalled.
//  4. in_en on the 8th word and flush in the same cycle
//     -> one full burst, mask 8'hFF, no partial burst; done follows.
//  5. rst_n low while idx=5 and the FIFO holds 2 bursts
//     -> out_valid=0, output_count=0 asynchronously; next start is clean.
//  6. WB_PERF_CNT_EN defined, out_ready low for 7 cycles with out_valid high
//     -> stall_cycles=7.

Source files
------------

// File: rtl/wb_packer.sv
// Writeback packer: gathers serial engine words into BURST_LEN-word bursts and queues them for the DMA.
// Optional feature macro: WB_PERF_CNT_EN adds the stall_cycles counter port.
module wb_packer #(
  parameter int BURST_LEN  = 8,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic                        flush,
  input  logic                        in_en,
  input  logic [DATA_W-1:0]           in_data,
  output logic [9:0]                  output_count,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W*BURST_LEN-1:0] out_data,
  output logic [ADDR_W-1:0]           out_addr,
  output logic [BURST_LEN-1:0]        out_mask,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow,
`ifdef WB_PERF_CNT_EN
  output logic [31:0]                 stall_cycles,
`endif
  output logic [1:0]                  state_dbg
);
  localparam int IDX_W   = $clog2(BURST_LEN);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LANES_W = DATA_W * BURST_LEN;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
  localparam logic [PTR_W:0]   DEPTH    = (PTR_W + 1)'(FIFO_DEPTH);

  // Handshake: a burst transfers on every cycle with out_valid && out_ready; while
  // out_valid is high and out_ready low, out_valid/out_data/out_addr/out_mask hold.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;
  state_t state_q, state_d;

  logic [IDX_W-1:0]     idx_q;
  logic [LANES_W-1:0]   lanes_q, lanes_w;
  logic [BURST_LEN-1:0] mask_q, mask_w;
  logic [ADDR_W-1:0]    addr_q;
  logic                 stage_vld;
  logic [LANES_W-1:0]   stage_data;
  logic [BURST_LEN-1:0] stage_mask;
  logic [ADDR_W-1:0]    stage_addr;

  logic [LANES_W-1:0]   mem_data [FIFO_DEPTH];
  logic [BURST_LEN-1:0] mem_mask [FIFO_DEPTH];
  logic [ADDR_W-1:0]    mem_addr [FIFO_DEPTH];
  logic [PTR_W:0]       wr_ptr, rd_ptr, fill;
  logic                 fifo_empty, fifo_full, pop, push, can_push;
  logic                 start_ok, take, last, enter_flush, partial, stage_load;

  assign start_ok    = (state_q == S_IDLE) && start;
  assign take        = (state_q == S_RUN) && in_en;
  assign last        = take && (idx_q == LAST_IDX);
  assign enter_flush = (state_q == S_RUN) && flush;
  // The word arriving with flush is packed first; only a non-empty remainder is pushed.
  assign partial     = enter_flush && !last && (take || (idx_q != '0));
  assign stage_load  = last || partial;

  assign fill       = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (fill == DEPTH);
  assign pop        = out_valid && out_ready;
  assign can_push   = !fifo_full || pop;
  assign push       = stage_vld && can_push;

  always_comb begin
    lanes_w = lanes_q;
    mask_w  = mask_q;
    if (take) begin
      lanes_w[idx_q*DATA_W +: DATA_W] = in_data;
      mask_w[idx_q]                   = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (flush) state_d = S_FLUSH;
      S_FLUSH: if (!stage_vld && fifo_empty) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Completed bursts go to a one-entry stage so packing of the next burst can start at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      lanes_q      <= '0;
      mask_q       <= '0;
      addr_q       <= '0;
      stage_vld    <= 1'b0;
      stage_data   <= '0;
      stage_mask   <= '0;
      stage_addr   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      output_count <= '0;
      overflow     <= 1'b0;
    end else if (start_ok) begin
      idx_q        <= '0;
      lanes_q      <= '0;
      mask_q       <= '0;
      addr_q       <= base_addr;
      stage_vld    <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      output_count <= '0;
      overflow     <= 1'b0;
    end else begin
      if (stage_load) begin
        stage_data <= lanes_w;
        stage_mask <= mask_w;
        stage_addr <= addr_q;
        addr_q     <= addr_q + ADDR_W'(1);
        idx_q      <= '0;
        lanes_q    <= '0;
        mask_q     <= '0;
      end else if (take) begin
        lanes_q <= lanes_w;
        mask_q  <= mask_w;
        idx_q   <= idx_q + IDX_W'(1);
      end
      if (take && (output_count != 10'h3FF)) output_count <= output_count + 10'd1;
      stage_vld <= stage_load;
      if (push)                   wr_ptr   <= wr_ptr + (PTR_W + 1)'(1);
      if (stage_vld && !can_push) overflow <= 1'b1;
      if (pop)                    rd_ptr   <= rd_ptr + (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr[PTR_W-1:0]] <= stage_data;
      mem_mask[wr_ptr[PTR_W-1:0]] <= stage_mask;
      mem_addr[wr_ptr[PTR_W-1:0]] <= stage_addr;
    end
  end

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? mem_data[rd_ptr[PTR_W-1:0]] : '0;
  assign out_mask  = out_valid ? mem_mask[rd_ptr[PTR_W-1:0]] : '0;
  assign out_addr  = out_valid ? mem_addr[rd_ptr[PTR_W-1:0]] : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

`ifdef WB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       stall_cycles <= '0;
    else if (start_ok)                stall_cycles <= '0;
    else if (out_valid && !out_ready) stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_wb_packer.sv
// Bench for wb_packer: table of packing/flush vectors plus hand-written stall, overflow,
// reset and saturation sequences; bursts are checked against a scoreboard queue.
module tb_wb_packer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [9:0]   base_addr = '0;
  logic         flush = 1'b0;
  logic         in_en = 1'b0;
  logic [15:0]  in_data = '0;
  logic [9:0]   output_count;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic [9:0]   out_addr;
  logic [7:0]   out_mask;
  logic         busy;
  logic         done;
  logic         overflow;
  logic [1:0]   state_dbg;
`ifdef WB_PERF_CNT_EN
  logic [31:0]  stall_cycles;
`endif

  wb_packer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .flush(flush),
    .in_en(in_en), .in_data(in_data), .output_count(output_count), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .out_mask(out_mask),
    .busy(busy), .done(done), .overflow(overflow),
`ifdef WB_PERF_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int done_cnt = 0;
  int got_rd = 0;
  logic [145:0] got_q[$];
  logic [145:0] exp_q[$];

  // Monitor: a burst is recorded on the negedge before the posedge that pops it.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back({out_addr, out_mask, out_data});
    if (rst_n && done) done_cnt++;
  end

  typedef struct {
    logic [9:0]  base;
    int          n;
    logic [15:0] seed;
    bit          flush_same;
    int          exp_bursts;
    logic [7:0]  exp_last_mask;
    logic [9:0]  exp_count;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_start(input logic [9:0] b);
    start = 1'b1;
    base_addr = b;
    cycle();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] d, input bit fl);
    in_en = 1'b1;
    in_data = d;
    flush = fl;
    cycle();
    in_en = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(name, 160'(seen), 160'(1));
    cycles(2);
  endtask

  // Expected bursts for n consecutive words seed, seed+1, ... from base, closed by a flush.
  function automatic void model_bursts(input logic [9:0] base, input int n, input logic [15:0] seed);
    logic [145:0] e;
    int cnt;
    for (int b = 0; b * 8 < n; b++) begin
      cnt = (n - b * 8 >= 8) ? 8 : n - b * 8;
      e = '0;
      e[145:136] = base + 10'(b);
      for (int k = 0; k < cnt; k++) begin
        e[128 + k] = 1'b1;
        e[k*16 +: 16] = seed + 16'(b * 8 + k);
      end
      exp_q.push_back(e);
    end
  endfunction

  task automatic compare_bursts(input string name);
    while (exp_q.size() > 0) begin
      if (got_rd < got_q.size()) begin
        check(name, 160'(got_q[got_rd]), 160'(exp_q[0]));
        got_rd++;
      end else begin
        check({name, "_missing"}, 160'(0), 160'(exp_q[0]));
      end
      void'(exp_q.pop_front());
    end
    check({name, "_extra"}, 160'(got_q.size() - got_rd), 160'(0));
    got_rd = got_q.size();
  endtask

  logic [145:0] snap;
  int d0;
  int nb;
  bit went_idle;

  initial begin
    vecs[0] = '{base:10'h010, n:8,  seed:16'h3C00, flush_same:1'b0, exp_bursts:1, exp_last_mask:8'hFF, exp_count:10'd8};
    vecs[1] = '{base:10'h010, n:11, seed:16'h4000, flush_same:1'b0, exp_bursts:2, exp_last_mask:8'h07, exp_count:10'd11};
    vecs[2] = '{base:10'h055, n:8,  seed:16'h7700, flush_same:1'b1, exp_bursts:1, exp_last_mask:8'hFF, exp_count:10'd8};
    vecs[3] = '{base:10'h3FF, n:16, seed:16'hA000, flush_same:1'b0, exp_bursts:2, exp_last_mask:8'hFF, exp_count:10'd16};
    vecs[4] = '{base:10'h123, n:3,  seed:16'hB000, flush_same:1'b1, exp_bursts:1, exp_last_mask:8'h07, exp_count:10'd3};
    vecs[5] = '{base:10'h200, n:0,  seed:16'h0000, flush_same:1'b0, exp_bursts:0, exp_last_mask:8'h00, exp_count:10'd0};
    vecs[6] = '{base:10'h301, n:1,  seed:16'hC0DE, flush_same:1'b0, exp_bursts:1, exp_last_mask:8'h01, exp_count:10'd1};

    // Reset state
    cycles(3);
    @(negedge clk);
    check("rst_valid", 160'(out_valid), 160'(0));
    check("rst_count", 160'(output_count), 160'(0));
    check("rst_busy", 160'({busy, done, overflow}), 160'(0));
    check("rst_burst", 160'({out_addr, out_mask, out_data}), 160'(0));
    check("rst_state", 160'(state_dbg), 160'(0));
    cycle();
    rst_n = 1'b1;
    cycles(2);

    // Table-driven packing and flush vectors, DMA always ready
    out_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      d0 = done_cnt;
      got_rd = got_q.size();
      do_start(vecs[v].base);
      for (int i = 0; i < vecs[v].n; i++)
        send_word(vecs[v].seed + 16'(i), vecs[v].flush_same && (i == vecs[v].n - 1));
      if (!vecs[v].flush_same) do_flush();
      wait_done($sformatf("v%0d_done_seen", v), 60);
      cycles(2);
      @(negedge clk);
      check($sformatf("v%0d_count", v), 160'(output_count), 160'(vecs[v].exp_count));
      nb = got_q.size() - got_rd;
      check($sformatf("v%0d_bursts", v), 160'(nb), 160'(vecs[v].exp_bursts));
      if (nb > 0)
        check($sformatf("v%0d_last_mask", v), 160'(got_q[got_q.size()-1][135:128]), 160'(vecs[v].exp_last_mask));
      check($sformatf("v%0d_done_pulses", v), 160'(done_cnt - d0), 160'(1));
      check($sformatf("v%0d_idle", v), 160'({busy, overflow}), 160'(0));
      model_bursts(vecs[v].base, vecs[v].n, vecs[v].seed);
      compare_bursts($sformatf("v%0d_burst", v));
      cycle();
      send_word(16'hDEAD, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_idle_in_en", v), 160'(output_count), 160'(vecs[v].exp_count));
      cycle();
    end

    // Latency, start ignored in RUN, stall stability and stall counter
    out_ready = 1'b0;
    got_rd = got_q.size();
    do_start(10'h030);
    for (int i = 0; i < 3; i++) send_word(16'h5000 + 16'(i), 1'b0);
    do_start(10'h0AA);
    for (int i = 3; i < 8; i++) send_word(16'h5000 + 16'(i), 1'b0);
    @(negedge clk);
    check("lat_pending", 160'(out_valid), 160'(0));
    cycle();
    @(negedge clk);
    check("lat_valid", 160'(out_valid), 160'(1));
    check("lat_word7", 160'(out_data[127:112]), 160'(16'h5007));
    check("start_ign_addr", 160'(out_addr), 160'(10'h030));
    check("start_ign_count", 160'(output_count), 160'(8));
    snap = {out_addr, out_mask, out_data};
    cycles(7);
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_stable", 160'({out_addr, out_mask, out_data}), 160'(snap));
`ifdef WB_PERF_CNT_EN
    check("stall_cycles", 160'(stall_cycles), 160'(7));
`endif
    cycle();
    @(negedge clk);
    check("stall_popped", 160'(out_valid), 160'(0));
    do_flush();
    wait_done("lat_done_seen", 60);
    model_bursts(10'h030, 8, 16'h5000);
    compare_bursts("lat_burst");

    // Overflow: 5 bursts into a 4-deep FIFO while stalled
    out_ready = 1'b0;
    got_rd = got_q.size();
    do_start(10'h020);
    for (int i = 0; i < 40; i++) send_word(16'h1000 + 16'(i), 1'b0);
    cycle();
    @(negedge clk);
    check("ovf_flag", 160'(overflow), 160'(1));
    check("ovf_head", 160'({out_valid, out_addr, out_mask}), 160'({1'b1, 10'h020, 8'hFF}));
    snap = {out_addr, out_mask, out_data};
    cycles(3);
    @(negedge clk);
    check("ovf_stable", 160'({out_addr, out_mask, out_data}), 160'(snap));
    cycle();
    out_ready = 1'b1;
    went_idle = 1'b0;
    for (int i = 0; i < 20 && !went_idle; i++) begin
      @(negedge clk);
      if (!out_valid) went_idle = 1'b1;
    end
    check("ovf_drained", 160'(went_idle), 160'(1));
    check("ovf_pops", 160'(got_q.size() - got_rd), 160'(4));
    model_bursts(10'h020, 32, 16'h1000);
    compare_bursts("ovf_burst");
    check("ovf_count", 160'(output_count), 160'(40));
    do_flush();
    wait_done("ovf_done_seen", 60);
    @(negedge clk);
    check("ovf_sticky", 160'(overflow), 160'(1));
    cycle();

    // Reset mid-burst with two bursts queued
    out_ready = 1'b0;
    do_start(10'h040);
    for (int i = 0; i < 21; i++) send_word(16'h2000 + 16'(i), 1'b0);
    @(negedge clk);
    check("rstmid_pre", 160'({out_valid, output_count}), 160'({1'b1, 10'd21}));
    #1 rst_n = 1'b0;
    #1;
    check("rstmid_async", 160'({out_valid, busy, output_count}), 160'(0));
    cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    got_rd = got_q.size();
    cycle();
    do_start(10'h100);
    for (int i = 0; i < 8; i++) send_word(16'h6000 + 16'(i), 1'b0);
    do_flush();
    wait_done("rstmid_done_seen", 60);
    @(negedge clk);
    check("rstmid_clean", 160'({overflow, output_count}), 160'({1'b0, 10'd8}));
    model_bursts(10'h100, 8, 16'h6000);
    compare_bursts("rstmid_burst");
    cycle();

    // output_count saturation
    do_start(10'h000);
    for (int i = 0; i < 1022; i++) send_word(16'(i), 1'b0);
    @(negedge clk);
    check("sat_below", 160'(output_count), 160'(10'h3FE));
    cycle();
    for (int i = 1022; i < 1030; i++) send_word(16'(i), 1'b0);
    @(negedge clk);
    check("sat_hold", 160'(output_count), 160'(10'h3FF));
    cycle();
    do_flush();
    wait_done("sat_done_seen", 60);
    got_rd = got_q.size();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
